handshake_constant_seq: RTL and testbench
=========================================

// Module: handshake_constant_seq
// PURPOSE
//  Elastic constant source: each ctrl token emits the next word of a parameter table.
//  Generalises the single-constant handshake source to NUM_CONSTS values.
//  Sequencing modes: wrap-around or saturate on the last entry.
//  A 2-slot registered buffer cuts the combinational ready/valid paths in both directions.
//  Sits in dataflow graphs wherever a control token must produce a literal or a literal sequence.
// PARAMETERS
//  DATA_WIDTH   32              width of each constant
//  NUM_CONSTS   4               table entries, >=1
//  CONST_TABLE  {NUM_CONSTS*DATA_WIDTH{1'b0}}  entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//  WRAP         1               1: after last entry return to entry 0; 0: repeat last entry forever
//  IDX_W        (NUM_CONSTS>1 ? $clog2(NUM_CONSTS) : 1)  index width (derived)
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           asynchronous, active-high reset
//  ctrl_valid  in   1           control token present
//  ctrl_ready  out  1           block can accept a token
//  outs        out  DATA_WIDTH  constant at buffer head
//  outs_valid  out  1           outs holds a valid word
//  outs_ready  in   1           consumer accepts outs
//  outs_idx    out  IDX_W       table index of the word on outs
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
//  Reset (async assert, sync release): count=0, idx=0, both slots and their indices = 0.
//   Outputs during reset: outs_valid=0, ctrl_ready=0, outs=0, outs_idx=0.
//  State:
//   - idx: next table entry to issue.
//   - 2-entry FIFO (slot data + slot index).
//   - count in {0,1,2}.
//  Push: ctrl_valid & ctrl_ready. Writes CONST_TABLE[idx] and idx into the tail slot, then advances idx:
//   - idx<NUM_CONSTS-1: idx+1.
//   - idx==NUM_CONSTS-1: 0 if WRAP=1, else unchanged.
//  Pop: outs_valid & outs_ready. Frees the head slot.
//  ctrl_ready = !rst & (count<2). Depends only on registered state, never on outs_ready.
//  outs_valid = (count!=0). outs/outs_idx are driven from the head slot only, registered, no comb path.
//  Latency: a token accepted at edge N is presented at outs after edge N (1 cycle).
//  Throughput: 1 token/cycle sustained when outs_ready=1.
//  Simultaneous push+pop:
//   - count=1: count stays 1, new word becomes head after edge.
//   - count=2: cannot occur (ctrl_ready=0).
//  count=0 with push only: the word appears next cycle; no bypass path.
//  Stability: while outs_valid & !outs_ready, outs and outs_idx hold unchanged.
//   The FIFO never reorders, drops or duplicates a word.
//  NUM_CONSTS=1: idx fixed at 0; behaves as a buffered single-constant source; WRAP has no effect.
//  Reset mid-operation: buffered words are discarded and idx returns to 0.
//   The first word after reset is always entry 0.
//  ctrl carries no data; only the handshake is consumed.
// TESTING
//  T1 NUM=4, table {A,B,C,D}, WRAP=1, outs_ready=1, ctrl_valid=1 for 6 cycles
//     -> outs A,B,C,D,A,B on consecutive cycles from cycle 1; outs_idx 0,1,2,3,0,1.
//  T2 outs_ready=0, ctrl_valid=1
//     -> exactly 2 accepts, then ctrl_ready=0; outs=A stable.
//     Raise outs_ready -> A,B,C,... in order, no gaps or duplicates.
//  T3 WRAP=0, 6 tokens, outs_ready=1 -> A,B,C,D,D,D; outs_idx saturates at 3.
//  T4 count=2, assert rst between edges
//     -> outs_valid and ctrl_ready drop without waiting for a clock edge.
//     Release, 1 token -> outs=A, outs_idx=0.
//  T5 NUM=1, table {0x5A5A5A5A} -> every token yields 0x5A5A5A5A; ctrl_ready never depends on outs_ready.
//  T6 10k cycles random ctrl_valid/outs_ready vs reference model
//     -> zero mismatches; outs stable while valid&!ready; count never >2.

Source files
------------

// File: rtl/handshake_constant_seq_if.sv
// Ready/valid bundle for the constant sequencer: control token in, indexed constant word out.
// The master modport is the source side (the sequencer); slave is the environment.
interface handshake_constant_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 2
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic [IDX_W-1:0]      outs_idx;

  modport master (
    input  ctrl_valid,
    output ctrl_ready,
    output outs,
    output outs_valid,
    input  outs_ready,
    output outs_idx
  );

  modport slave (
    output ctrl_valid,
    input  ctrl_ready,
    input  outs,
    input  outs_valid,
    output outs_ready,
    input  outs_idx
  );
endinterface

// File: rtl/handshake_constant_seq.sv
// Elastic constant source: each accepted control token enqueues the next table word
// into a 2-slot registered FIFO, so ready and valid never have a combinational path.
module handshake_constant_seq #(
  parameter int                              DATA_WIDTH  = 32,
  parameter int                              NUM_CONSTS  = 4,
  parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONST_TABLE = '0,
  parameter int                              WRAP        = 1,
  parameter int                              IDX_W       = (NUM_CONSTS > 1) ? $clog2(NUM_CONSTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  handshake_constant_seq_if.master  bus
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [IDX_W-1:0]      head_idx_q, head_idx_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [IDX_W-1:0]      tail_idx_q, tail_idx_d;

  logic                  ctrl_ready;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] const_word;

  assign ctrl_ready     = !rst && (state_q != S_FULL);
  assign push           = bus.ctrl_valid && ctrl_ready;
  assign pop            = bus.outs_ready && (state_q != S_EMPTY);

  assign bus.ctrl_ready = ctrl_ready;
  assign bus.outs_valid = (state_q != S_EMPTY);
  assign bus.outs       = head_q;
  assign bus.outs_idx   = head_idx_q;

  always_comb begin
    const_word = '0;
    for (int unsigned i = 0; i < NUM_CONSTS; i++) begin
      if (idx_q == IDX_W'(i)) const_word = CONST_TABLE[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Table index: advance on every accepted token, wrapping or sticking at the last entry.
  always_comb begin
    idx_d = idx_q;
    if (push) begin
      if (idx_q == IDX_W'(NUM_CONSTS - 1)) idx_d = (WRAP != 0) ? '0 : idx_q;
      else                                 idx_d = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    head_idx_d = head_idx_q;
    tail_d     = tail_q;
    tail_idx_d = tail_idx_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          head_d     = const_word;
          head_idx_d = idx_q;
          state_d    = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          head_d     = const_word;
          head_idx_d = idx_q;
        end else if (push) begin
          tail_d     = const_word;
          tail_idx_d = idx_q;
          state_d    = S_FULL;
        end else if (pop) begin
          state_d    = S_EMPTY;
        end
      end
      S_FULL: begin
        // ctrl_ready is low here, so only a pop can happen: tail moves up to head.
        if (pop) begin
          head_d     = tail_q;
          head_idx_d = tail_idx_q;
          state_d    = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      idx_q      <= '0;
      head_q     <= '0;
      head_idx_q <= '0;
      tail_q     <= '0;
      tail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      head_q     <= head_d;
      head_idx_q <= head_idx_d;
      tail_q     <= tail_d;
      tail_idx_q <= tail_idx_d;
    end
  end

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: three configurations (wrap, saturate, single entry)
// checked every cycle against a token-counting model, plus directed literal checks.
module tb_handshake_constant_seq;

  localparam logic [31:0] A = 32'h1111_AAAA;
  localparam logic [31:0] B = 32'h2222_BBBB;
  localparam logic [31:0] C = 32'h3333_CCCC;
  localparam logic [31:0] D = 32'h4444_DDDD;
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic clk;
  logic cv   [3];
  logic ordy [3];
  logic rst  [3];

  int checks = 0;
  int errors = 0;

  handshake_constant_seq_if #(.DATA_WIDTH(32), .IDX_W(2)) if0 ();
  handshake_constant_seq_if #(.DATA_WIDTH(32), .IDX_W(2)) if1 ();
  handshake_constant_seq_if #(.DATA_WIDTH(32), .IDX_W(1)) if2 ();

  assign if0.ctrl_valid = cv[0];
  assign if0.outs_ready = ordy[0];
  assign if1.ctrl_valid = cv[1];
  assign if1.outs_ready = ordy[1];
  assign if2.ctrl_valid = cv[2];
  assign if2.outs_ready = ordy[2];

  handshake_constant_seq #(.DATA_WIDTH(32), .NUM_CONSTS(4), .CONST_TABLE({D, C, B, A}), .WRAP(1)) dut0 (
    .clk (clk), .rst (rst[0]), .bus (if0.master));
  handshake_constant_seq #(.DATA_WIDTH(32), .NUM_CONSTS(4), .CONST_TABLE({D, C, B, A}), .WRAP(0)) dut1 (
    .clk (clk), .rst (rst[1]), .bus (if1.master));
  handshake_constant_seq #(.DATA_WIDTH(32), .NUM_CONSTS(1), .CONST_TABLE(K), .WRAP(1)) dut2 (
    .clk (clk), .rst (rst[2]), .bus (if2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input int d, input int i);
    if (d == 2) return K;
    case (i)
      0:       return A;
      1:       return B;
      2:       return C;
      default: return D;
    endcase
  endfunction

  // Table index of the k-th token issued since reset.
  function automatic int seq_idx(input int d, input int k);
    int n;
    n = (d == 2) ? 1 : 4;
    if (d != 1) return k % n;
    return (k < n - 1) ? k : n - 1;
  endfunction

  // Model: tokens accepted and words consumed since the last reset.
  int acc  [3] = '{0, 0, 0};
  int pops [3] = '{0, 0, 0};

  always @(negedge clk) begin
    logic        a_valid [3];
    logic        a_ready [3];
    logic [31:0] a_outs  [3];
    logic [31:0] a_idx   [3];
    a_valid[0] = if0.outs_valid; a_ready[0] = if0.ctrl_ready; a_outs[0] = if0.outs; a_idx[0] = 32'(if0.outs_idx);
    a_valid[1] = if1.outs_valid; a_ready[1] = if1.ctrl_ready; a_outs[1] = if1.outs; a_idx[1] = 32'(if1.outs_idx);
    a_valid[2] = if2.outs_valid; a_ready[2] = if2.ctrl_ready; a_outs[2] = if2.outs; a_idx[2] = 32'(if2.outs_idx);
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        acc[d]  = 0;
        pops[d] = 0;
        check($sformatf("d%0d rst outs_valid", d), 32'(a_valid[d]), 32'd0);
        check($sformatf("d%0d rst ctrl_ready", d), 32'(a_ready[d]), 32'd0);
        check($sformatf("d%0d rst outs", d), a_outs[d], 32'd0);
        check($sformatf("d%0d rst outs_idx", d), a_idx[d], 32'd0);
      end else begin
        bit exp_valid, exp_ready, do_push, do_pop;
        exp_valid = (acc[d] > pops[d]);
        exp_ready = (acc[d] - pops[d] < 2);
        check($sformatf("d%0d ctrl_ready", d), 32'(a_ready[d]), 32'(exp_ready));
        check($sformatf("d%0d outs_valid", d), 32'(a_valid[d]), 32'(exp_valid));
        if (exp_valid) begin
          check($sformatf("d%0d outs", d), a_outs[d], word(d, seq_idx(d, pops[d])));
          check($sformatf("d%0d outs_idx", d), a_idx[d], 32'(seq_idx(d, pops[d])));
        end
        do_push = cv[d] && exp_ready;
        do_pop  = ordy[d] && exp_valid;
        if (do_push) acc[d]++;
        if (do_pop)  pops[d]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v, input logic r);
    for (int d = 0; d < 3; d++) begin
      cv[d]   = v;
      ordy[d] = r;
    end
  endtask

  task automatic reset_all();
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    step();
    step();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  logic [31:0] exp_t1 [6];
  logic [31:0] exp_t3 [6];
  logic [31:0] exp_t2w [4];
  logic [31:0] exp_t2s [4];

  initial begin
    exp_t1  = '{A, B, C, D, A, B};
    exp_t3  = '{A, B, C, D, D, D};
    exp_t2w = '{B, C, D, A};
    exp_t2s = '{B, C, D, D};
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; cv[d] = 1'b0; ordy[d] = 1'b0;
    end
    #1;
    check("lit reset outs_valid", 32'(if0.outs_valid), 32'd0);
    check("lit reset ctrl_ready", 32'(if0.ctrl_ready), 32'd0);
    reset_all();

    // Streaming: wrap, saturate and single-entry side by side.
    set_all(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 5) set_all(1'b0, 1'b1);
      check($sformatf("lit t1 outs[%0d]", k), if0.outs, exp_t1[k]);
      check($sformatf("lit t1 idx[%0d]", k), 32'(if0.outs_idx), 32'(k % 4));
      check($sformatf("lit t3 outs[%0d]", k), if1.outs, exp_t3[k]);
      check($sformatf("lit t3 idx[%0d]", k), 32'(if1.outs_idx), 32'((k < 3) ? k : 3));
      check($sformatf("lit t5 outs[%0d]", k), if2.outs, K);
    end
    step();
    check("lit t1 drained", 32'(if0.outs_valid), 32'd0);

    // Backpressure: two accepts, then stall with A held at the head.
    reset_all();
    set_all(1'b1, 1'b0);
    step();
    check("lit t2 ready after 1", 32'(if0.ctrl_ready), 32'd1);
    check("lit t2 head A", if0.outs, A);
    for (int k = 0; k < 4; k++) begin
      step();
      check("lit t2 ready full", 32'(if0.ctrl_ready), 32'd0);
      check("lit t2 head stable", if0.outs, A);
      check("lit t5 ready full", 32'(if2.ctrl_ready), 32'd0);
    end
    set_all(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("lit t2 drain[%0d]", k), if0.outs, exp_t2w[k]);
      check($sformatf("lit t2 sat drain[%0d]", k), if1.outs, exp_t2s[k]);
      check($sformatf("lit t2 valid[%0d]", k), 32'(if0.outs_valid), 32'd1);
    end

    // Asynchronous reset with both slots full.
    set_all(1'b1, 1'b0);
    step();
    step();
    check("lit t4 full ready", 32'(if0.ctrl_ready), 32'd0);
    check("lit t4 full valid", 32'(if0.outs_valid), 32'd1);
    #2;
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    #1;
    check("lit t4 async valid", 32'(if0.outs_valid), 32'd0);
    check("lit t4 async ready", 32'(if0.ctrl_ready), 32'd0);
    check("lit t4 async outs", if0.outs, 32'd0);
    step();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    set_all(1'b1, 1'b1);
    step();
    set_all(1'b0, 1'b1);
    check("lit t4 first A", if0.outs, A);
    check("lit t4 first idx", 32'(if0.outs_idx), 32'd0);
    check("lit t4 first valid", 32'(if0.outs_valid), 32'd1);
    step();

    // Random traffic with occasional resets; the negedge model checks every cycle.
    for (int n = 0; n < 10000; n++) begin
      for (int d = 0; d < 3; d++) begin
        cv[d]   = ($urandom_range(0, 3) != 0);
        ordy[d] = $urandom_range(0, 1) != 0;
        rst[d]  = ($urandom_range(0, 499) == 0);
      end
      step();
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
